// File: rtl/pingpang_ram_ctrl.sv
// Ping-pong controller: fills one external RAM bank from the input
// stream while the previously filled bank is drained to dout.
module pingpang_ram_ctrl #(
    parameter int DW    = 8,
    parameter int DEPTH = 100,
    parameter int AW    = 7
) (
    input  logic          clk_50m,
    input  logic          rst_n,
    input  logic          data_en,
    input  logic [DW-1:0] data_in,
    input  logic          rd_ready,
    output logic [DW-1:0] ram_wr_data,
    output logic          ram_a_wr_en,
    output logic          ram_b_wr_en,
    output logic [AW-1:0] ram_wr_addr,
    output logic          ram_a_rd_en,
    output logic          ram_b_rd_en,
    output logic [AW-1:0] ram_rd_addr,
    input  logic [DW-1:0] ram_a_rd_data,
    input  logic [DW-1:0] ram_b_rd_data,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          dout_bank,
    output logic          overrun
);

    typedef enum logic {
        WR_A,
        WR_B
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_A,
        RD_B
    } rd_state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    function automatic rd_state_t bank_rd(input logic b);
        return b ? RD_B : RD_A;
    endfunction

    wr_state_t     wr_state;
    wr_state_t     wr_next;
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] wr_cnt_next;
    logic          full_evt;
    logic          full_bank;

    rd_state_t     rd_state;
    rd_state_t     rd_next;
    logic [AW-1:0] rd_cnt;
    logic [AW-1:0] rd_cnt_next;
    logic          pend;
    logic          pend_next;
    logic          pend_bank;
    logic          pend_bank_next;
    logic          overrun_next;
    logic          rd_active;
    logic          rd_issue;
    logic          rd_last;

    logic          rd_v1;
    logic          rd_b1;

    // Write FSM: the bank flips on the word that lands at DEPTH-1.
    always_comb begin
        wr_next     = wr_state;
        wr_cnt_next = wr_cnt;
        full_evt    = 1'b0;
        full_bank   = (wr_state == WR_B);
        if (data_en) begin
            if (wr_cnt == LAST) begin
                wr_cnt_next = '0;
                full_evt    = 1'b1;
                wr_next     = (wr_state == WR_A) ? WR_B : WR_A;
            end else begin
                wr_cnt_next = wr_cnt + AW'(1);
            end
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            wr_state    <= WR_A;
            wr_cnt      <= '0;
            ram_wr_data <= '0;
            ram_wr_addr <= '0;
            ram_a_wr_en <= 1'b0;
            ram_b_wr_en <= 1'b0;
        end else begin
            wr_state    <= wr_next;
            wr_cnt      <= wr_cnt_next;
            ram_a_wr_en <= data_en && (wr_state == WR_A);
            ram_b_wr_en <= data_en && (wr_state == WR_B);
            if (data_en) begin
                ram_wr_data <= data_in;
                ram_wr_addr <= wr_cnt;
            end
        end
    end

    assign rd_active   = (rd_state != RD_IDLE);
    assign rd_issue    = rd_active && rd_ready;
    assign rd_last     = rd_issue && (rd_cnt == LAST);
    assign ram_a_rd_en = rd_issue && (rd_state == RD_A);
    assign ram_b_rd_en = rd_issue && (rd_state == RD_B);
    assign ram_rd_addr = rd_cnt;

    // Read FSM; a finishing drain may hand off to a new bank in the
    // same cycle, so the last read and a full pulse never collide.
    always_comb begin
        rd_next        = rd_state;
        rd_cnt_next    = rd_cnt;
        pend_next      = pend;
        pend_bank_next = pend_bank;
        overrun_next   = overrun;
        if (rd_issue) begin
            rd_cnt_next = rd_cnt + AW'(1);
        end
        if (rd_last) begin
            rd_next     = RD_IDLE;
            rd_cnt_next = '0;
        end
        if (full_evt) begin
            if (pend) begin
                overrun_next   = 1'b1;
                pend_bank_next = full_bank;
            end else if (rd_active && !rd_last) begin
                pend_next      = 1'b1;
                pend_bank_next = full_bank;
            end
        end
        if (!rd_active || rd_last) begin
            if (full_evt) begin
                rd_next     = bank_rd(full_bank);
                rd_cnt_next = '0;
                pend_next   = 1'b0;
            end else if (pend) begin
                rd_next     = bank_rd(pend_bank);
                rd_cnt_next = '0;
                pend_next   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rd_state  <= RD_IDLE;
            rd_cnt    <= '0;
            pend      <= 1'b0;
            pend_bank <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rd_state  <= rd_next;
            rd_cnt    <= rd_cnt_next;
            pend      <= pend_next;
            pend_bank <= pend_bank_next;
            overrun   <= overrun_next;
        end
    end

    // RAM data arrives one cycle after rd_en; register it once more.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1      <= 1'b0;
            rd_b1      <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_bank  <= 1'b0;
        end else begin
            rd_v1      <= ram_a_rd_en || ram_b_rd_en;
            rd_b1      <= ram_b_rd_en;
            dout_valid <= rd_v1;
            if (rd_v1) begin
                dout      <= rd_b1 ? ram_b_rd_data : ram_a_rd_data;
                dout_bank <= rd_b1;
            end
        end
    end

endmodule

// File: tb/tb_pingpang_ram_ctrl.sv
// Directed bench for pingpang_ram_ctrl with behavioural RAM banks,
// covering DEPTH=100 and a DEPTH=4 instance.
module tb_pingpang_ram_ctrl;

    logic       clk_50m = 1'b0;
    logic       rst_n   = 1'b0;
    always #10 clk_50m = ~clk_50m;

    logic       data_en, rd_ready;
    logic [7:0] data_in;
    logic [7:0] wr_data, a_q, b_q, dout;
    logic       a_wr, b_wr, a_rd, b_rd;
    logic [6:0] wr_addr, rd_addr;
    logic       dout_valid, dout_bank, overrun;

    logic       s_data_en, s_rd_ready;
    logic [7:0] s_data_in;
    logic [7:0] s_wr_data, s_a_q, s_b_q, s_dout;
    logic       s_a_wr, s_b_wr, s_a_rd, s_b_rd;
    logic [1:0] s_wr_addr, s_rd_addr;
    logic       s_dout_valid, s_dout_bank, s_overrun;

    int n_cmp = 0;
    int n_err = 0;

    pingpang_ram_ctrl #(.DW(8), .DEPTH(100), .AW(7)) dut (
        .clk_50m(clk_50m), .rst_n(rst_n),
        .data_en(data_en), .data_in(data_in), .rd_ready(rd_ready),
        .ram_wr_data(wr_data), .ram_a_wr_en(a_wr), .ram_b_wr_en(b_wr),
        .ram_wr_addr(wr_addr), .ram_a_rd_en(a_rd), .ram_b_rd_en(b_rd),
        .ram_rd_addr(rd_addr), .ram_a_rd_data(a_q), .ram_b_rd_data(b_q),
        .dout(dout), .dout_valid(dout_valid), .dout_bank(dout_bank),
        .overrun(overrun)
    );

    pingpang_ram_ctrl #(.DW(8), .DEPTH(4), .AW(2)) dut4 (
        .clk_50m(clk_50m), .rst_n(rst_n),
        .data_en(s_data_en), .data_in(s_data_in), .rd_ready(s_rd_ready),
        .ram_wr_data(s_wr_data), .ram_a_wr_en(s_a_wr), .ram_b_wr_en(s_b_wr),
        .ram_wr_addr(s_wr_addr), .ram_a_rd_en(s_a_rd), .ram_b_rd_en(s_b_rd),
        .ram_rd_addr(s_rd_addr), .ram_a_rd_data(s_a_q), .ram_b_rd_data(s_b_q),
        .dout(s_dout), .dout_valid(s_dout_valid), .dout_bank(s_dout_bank),
        .overrun(s_overrun)
    );

    logic [7:0] mem_a [0:127];
    logic [7:0] mem_b [0:127];
    logic [7:0] s_mem_a [0:3];
    logic [7:0] s_mem_b [0:3];

    always @(posedge clk_50m) begin
        if (a_wr) mem_a[wr_addr] <= wr_data;
        if (b_wr) mem_b[wr_addr] <= wr_data;
        if (a_rd) a_q <= mem_a[rd_addr];
        if (b_rd) b_q <= mem_b[rd_addr];
        if (s_a_wr) s_mem_a[s_wr_addr] <= s_wr_data;
        if (s_b_wr) s_mem_b[s_wr_addr] <= s_wr_data;
        if (s_a_rd) s_a_q <= s_mem_a[s_rd_addr];
        if (s_b_rd) s_b_q <= s_mem_b[s_rd_addr];
    end

    // Leaves time at posedge+1 of cycle 0 with reset released.
    task automatic do_reset();
        rst_n = 1'b0;
        data_en = 1'b0; data_in = 8'h00; rd_ready = 1'b0;
        s_data_en = 1'b0; s_data_in = 8'h00; s_rd_ready = 1'b0;
        repeat (3) @(posedge clk_50m);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [36:0] g;
        logic [27:0] gs;
        rst_n = 1'b0;
        data_en = 1'b0; data_in = 8'h00; rd_ready = 1'b0;
        s_data_en = 1'b0; s_data_in = 8'h00; s_rd_ready = 1'b0;
        repeat (2) @(posedge clk_50m);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            g = {wr_data, a_wr, b_wr, wr_addr, a_rd, b_rd, rd_addr,
                 dout, dout_valid, dout_bank, overrun};
            gs = {s_wr_data, s_a_wr, s_b_wr, s_wr_addr, s_a_rd, s_b_rd,
                  s_rd_addr, s_dout, s_dout_valid, s_dout_bank, s_overrun};
            n_cmp++;
            if (g !== '0) begin
                n_err++;
                $display("FAIL reset_outs k=%0d got %h want 0", k, g);
            end
            n_cmp++;
            if (gs !== '0) begin
                n_err++;
                $display("FAIL reset_outs4 k=%0d got %h want 0", k, gs);
            end
            @(posedge clk_50m);
        end
    endtask

    task automatic test_stream();
        int j, r, d;
        logic [16:0] ew, gw;
        logic [8:0]  er, gr;
        logic [10:0] ed, gd;
        do_reset();
        for (int k = 0; k <= 320; k++) begin
            data_en = 1'b1; data_in = 8'(k % 200); rd_ready = 1'b1;
            #1;
            if (k == 0) ew = '0;
            else begin
                j = k - 1;
                ew = {((j / 100) % 2) == 0, ((j / 100) % 2) == 1,
                      7'(j % 100), 8'(j % 200)};
            end
            gw = {a_wr, b_wr, wr_addr, wr_data};
            n_cmp++;
            if (gw !== ew) begin
                n_err++;
                $display("FAIL stream_wr k=%0d got %h want %h", k, gw, ew);
            end
            if (k < 100) er = '0;
            else begin
                r = k - 100;
                er = {((r / 100) % 2) == 0, ((r / 100) % 2) == 1,
                      7'(r % 100)};
            end
            gr = {a_rd, b_rd, rd_addr};
            n_cmp++;
            if (gr !== er) begin
                n_err++;
                $display("FAIL stream_rd k=%0d got %h want %h", k, gr, er);
            end
            if (k < 102) ed = '0;
            else begin
                d = k - 102;
                ed = {1'b1, ((d / 100) % 2) == 1, 8'(d % 200), 1'b0};
            end
            gd = {dout_valid, dout_bank, dout, overrun};
            n_cmp++;
            if (gd !== ed) begin
                n_err++;
                $display("FAIL stream_dout k=%0d got %h want %h", k, gd, ed);
            end
            @(posedge clk_50m); #1;
        end
    endtask

    task automatic test_toggle();
        int j;
        logic [16:0] ew, gw;
        logic [8:0]  er, gr;
        logic [10:0] ed, gd;
        do_reset();
        for (int k = 0; k <= 305; k++) begin
            data_en = (k % 2 == 0); data_in = 8'(k / 2); rd_ready = 1'b1;
            #1;
            if (k % 2 == 1) begin
                j = (k - 1) / 2;
                ew = {((j / 100) % 2) == 0, ((j / 100) % 2) == 1,
                      7'(j % 100), 8'(j)};
                gw = {a_wr, b_wr, wr_addr, wr_data};
            end else begin
                ew = '0;
                gw = {a_wr, b_wr, 15'h0};
            end
            n_cmp++;
            if (gw !== ew) begin
                n_err++;
                $display("FAIL toggle_wr k=%0d got %h want %h", k, gw, ew);
            end
            if (k >= 199 && k <= 298) er = {2'b10, 7'(k - 199)};
            else er = '0;
            gr = {a_rd, b_rd, rd_addr};
            n_cmp++;
            if (gr !== er) begin
                n_err++;
                $display("FAIL toggle_rd k=%0d got %h want %h", k, gr, er);
            end
            if (k <= 300) begin
                if (k < 201) ed = '0;
                else ed = {2'b10, 8'(k - 201), 1'b0};
                gd = {dout_valid, dout_bank, dout, overrun};
            end else begin
                ed = '0;
                gd = {dout_valid, 9'h0, overrun};
            end
            n_cmp++;
            if (gd !== ed) begin
                n_err++;
                $display("FAIL toggle_dout k=%0d got %h want %h", k, gd, ed);
            end
            @(posedge clk_50m); #1;
        end
    endtask

    task automatic test_stall();
        int nr, r;
        int iss [0:340];
        logic [8:0]  er, gr;
        logic [10:0] ed, gd;
        logic        go;
        nr = 0;
        for (int i = 0; i <= 340; i++) iss[i] = -1;
        do_reset();
        for (int k = 0; k <= 330; k++) begin
            data_en = 1'b1; data_in = 8'(k % 200);
            rd_ready = !(k >= 150 && k <= 169);
            #1;
            go = (k >= 100) && rd_ready;
            r = nr;
            er = {go && ((r / 100) % 2) == 0, go && ((r / 100) % 2) == 1,
                  7'(r % 100)};
            if (go) begin
                iss[k] = r;
                nr++;
            end
            gr = {a_rd, b_rd, rd_addr};
            n_cmp++;
            if (gr !== er) begin
                n_err++;
                $display("FAIL stall_rd k=%0d got %h want %h", k, gr, er);
            end
            if (k >= 2 && iss[k-2] >= 0) begin
                ed = {1'b1, ((iss[k-2] / 100) % 2) == 1,
                      8'(iss[k-2] % 200), 1'b0};
                gd = {dout_valid, dout_bank, dout, overrun};
            end else begin
                ed = '0;
                gd = {dout_valid, 9'h0, overrun};
            end
            n_cmp++;
            if (gd !== ed) begin
                n_err++;
                $display("FAIL stall_dout k=%0d got %h want %h", k, gd, ed);
            end
            @(posedge clk_50m); #1;
        end
    endtask

    task automatic test_overrun();
        logic [8:0] er, gr;
        do_reset();
        for (int k = 0; k <= 360; k++) begin
            data_en = 1'b1; data_in = 8'(k % 200); rd_ready = (k >= 250);
            #1;
            if (k < 250) er = '0;
            else er = {2'b10, 7'((k - 250) % 100)};
            gr = {a_rd, b_rd, rd_addr};
            n_cmp++;
            if (gr !== er) begin
                n_err++;
                $display("FAIL ovr_rd k=%0d got %h want %h", k, gr, er);
            end
            n_cmp++;
            if (overrun !== (k >= 300)) begin
                n_err++;
                $display("FAIL ovr_flag k=%0d got %b want %b",
                         k, overrun, (k >= 300));
            end
            @(posedge clk_50m); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [36:0] g;
        do_reset();
        for (int k = 0; k < 158; k++) begin
            data_en = 1'b1; data_in = 8'(k % 200); rd_ready = 1'b1;
            @(posedge clk_50m); #1;
        end
        n_cmp++;
        if ({b_wr, wr_addr} !== {1'b1, 7'd57}) begin
            n_err++;
            $display("FAIL mid_pre got %b/%0d want 1/57", b_wr, wr_addr);
        end
        rst_n = 1'b0; data_en = 1'b0;
        #1;
        g = {wr_data, a_wr, b_wr, wr_addr, a_rd, b_rd, rd_addr,
             dout, dout_valid, dout_bank, overrun};
        n_cmp++;
        if (g !== '0) begin
            n_err++;
            $display("FAIL mid_reset got %h want 0", g);
        end
        repeat (2) @(posedge clk_50m);
        #1 rst_n = 1'b1;
        for (int k = 0; k <= 104; k++) begin
            data_en = 1'b1; data_in = 8'(8'h40 + k); rd_ready = 1'b1;
            #1;
            if (k == 1) begin
                n_cmp++;
                if ({a_wr, b_wr, wr_addr, wr_data} !== {2'b10, 7'd0, 8'h40}) begin
                    n_err++;
                    $display("FAIL mid_first_wr got %b%b/%0d/%h want 10/0/40",
                             a_wr, b_wr, wr_addr, wr_data);
                end
            end
            if (k == 100) begin
                n_cmp++;
                if ({a_rd, b_rd, rd_addr} !== {2'b10, 7'd0}) begin
                    n_err++;
                    $display("FAIL mid_first_rd got %b%b/%0d want 10/0",
                             a_rd, b_rd, rd_addr);
                end
            end
            if (k < 102) begin
                n_cmp++;
                if (dout_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL mid_early_valid k=%0d got 1 want 0", k);
                end
            end
            if (k == 102) begin
                n_cmp++;
                if ({dout_valid, dout_bank, dout} !== {2'b10, 8'h40}) begin
                    n_err++;
                    $display("FAIL mid_first_dout got %b%b/%h want 10/40",
                             dout_valid, dout_bank, dout);
                end
            end
            @(posedge clk_50m); #1;
        end
    endtask

    task automatic test_small_depth();
        int j, r, d;
        logic [11:0] ew, gw;
        logic [3:0]  er, gr;
        logic [10:0] ed, gd;
        do_reset();
        for (int k = 0; k <= 40; k++) begin
            s_data_en = 1'b1; s_data_in = 8'(k); s_rd_ready = 1'b1;
            #1;
            if (k == 0) ew = '0;
            else begin
                j = k - 1;
                ew = {((j / 4) % 2) == 0, ((j / 4) % 2) == 1,
                      2'(j % 4), 8'(j)};
            end
            gw = {s_a_wr, s_b_wr, s_wr_addr, s_wr_data};
            n_cmp++;
            if (gw !== ew) begin
                n_err++;
                $display("FAIL d4_wr k=%0d got %h want %h", k, gw, ew);
            end
            if (k < 4) er = '0;
            else begin
                r = k - 4;
                er = {((r / 4) % 2) == 0, ((r / 4) % 2) == 1, 2'(r % 4)};
            end
            gr = {s_a_rd, s_b_rd, s_rd_addr};
            n_cmp++;
            if (gr !== er) begin
                n_err++;
                $display("FAIL d4_rd k=%0d got %h want %h", k, gr, er);
            end
            if (k < 6) ed = '0;
            else begin
                d = k - 6;
                ed = {1'b1, ((d / 4) % 2) == 1, 8'(d), 1'b0};
            end
            gd = {s_dout_valid, s_dout_bank, s_dout, s_overrun};
            n_cmp++;
            if (gd !== ed) begin
                n_err++;
                $display("FAIL d4_dout k=%0d got %h want %h", k, gd, ed);
            end
            @(posedge clk_50m); #1;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_toggle();
        test_stall();
        test_overrun();
        test_reset_mid();
        test_small_depth();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pingpang_ram_ctrl.md
Name: pingpang_ram_ctrl

Overview:
Ping-pong buffer controller between the 8-bit stream generator and two external simple-dual-port RAM banks (A, B).
- Writes the incoming stream into one bank while the other, already full, bank is read out.
- Swaps banks on every full-bank boundary.
- Presents the read-back stream with a valid strobe and bank tag, and flags overrun when the reader falls behind.

Parameters:
DW, 8, data width
DEPTH, 100, words per bank; one full fill or drain
AW, 7, address width; must satisfy 2^AW >= DEPTH

Ports:
clk_50m  in  1  system clock, 50 MHz
rst_n  in  1  reset
data_en  in  1  input word valid
data_in  in  DW  input word
rd_ready  in  1  downstream throttle; read address advances only when high
ram_wr_data  out  DW  write data, shared by both banks
ram_a_wr_en  out  1  bank A write enable
ram_b_wr_en  out  1  bank B write enable
ram_wr_addr  out  AW  write address, shared
ram_a_rd_en  out  1  bank A read enable
ram_b_rd_en  out  1  bank B read enable
ram_rd_addr  out  AW  read address, shared
ram_a_rd_data  in  DW  bank A read data; valid 1 cycle after ram_a_rd_en
ram_b_rd_data  in  DW  bank B read data; valid 1 cycle after ram_b_rd_en
dout  out  DW  read-back word
dout_valid  out  1  dout qualifier
dout_bank  out  1  source bank of dout: 0 = A, 1 = B
overrun  out  1  sticky error flag

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk_50m. All outputs reset to 0. Write FSM resets to WR_A, read FSM to RD_IDLE, both address counters to 0, pend flag to 0.
- Write path is registered, 1-cycle latency. On a cycle with data_en=1:
  - ram_wr_data <= data_in
  - ram_wr_addr <= wr_cnt
  - the write enable of the current bank pulses for 1 cycle
  - wr_cnt increments
  - With data_en=0: no enables, counter holds.
- Write FSM:
  - WR_A -> WR_B when a word is accepted with wr_cnt == DEPTH-1.
  - WR_B -> WR_A likewise.
  - On the switch, wr_cnt returns to 0 and a 1-cycle internal full pulse is raised, tagged with the completed bank.
- Read FSM, states RD_IDLE, RD_A, RD_B:
  - A full pulse (or a set pend flag) in RD_IDLE enters RD_x for the completed bank x, with rd_cnt = 0.
  - In RD_x, on each cycle with rd_ready=1: ram_x_rd_en=1, ram_rd_addr=rd_cnt, rd_cnt increments.
  - After issuing address DEPTH-1: go to RD_IDLE, or directly to the pending bank if pend is set, with no idle gap.
  - rd_ready=0 holds the state and rd_cnt, and drives no rd_en.
- Output timing: dout/dout_valid/dout_bank are registered from the RAM data. dout_valid goes high exactly 2 cycles after the corresponding rd_en, independent of later rd_ready.
- Overrun:
  - A full pulse arriving while the read FSM is not in RD_IDLE and has not finished sets pend, recording the bank.
  - A full pulse while pend is already set sets overrun; the pending bank tag is overwritten with the newest bank.
  - overrun clears only on reset.
  - Writes are never blocked; data corruption under overrun is accepted and flagged.
- Simultaneous events:
  - The last read of a drain and a full pulse in the same cycle is a normal hand-off, with no pend and no overrun.
  - data_en and rd_ready are fully independent.
- With continuous data_en and rd_ready=1, the drain of one bank ends exactly as the next fill completes, and overrun never sets.
- Reset mid-fill or mid-drain aborts immediately; partial bank contents are discarded and the next fill restarts at bank A, address 0.

Test Plan:
- Continuous stream 0..199 wrapping, data_en=1 from cycle 0, rd_ready=1:
  - ram_a_wr_en at cycles 1..100 with addr 0..99 and data 0..99; bank B gets 100..199.
  - ram_a_rd_en at cycles 100..199; dout_valid from cycle 102, dout 0..99 with dout_bank=0, then 100..199 with dout_bank=1; overrun stays 0.
- data_en toggling every other cycle: bank A full after 100 accepted words (about 199 cycles), write addresses remain contiguous 0..99, dout still 0..99 in order.
- rd_ready=0 for 20 cycles mid-drain of bank A: rd_cnt holds, no rd_en, dout_valid gap of 20 cycles, no lost or duplicated words; overrun=0 while the stall ends before B is full.
- rd_ready=0 for 250 cycles with a continuous stream: pend set when B is full, overrun set when A refills; after rd_ready=1, read resumes and overrun stays 1.
- Assert rst_n=0 at write address 57 of bank B: all outputs 0 next cycle. After release, writes restart at bank A address 0, and the first dout is the first post-reset word.
- DEPTH=4, AW=2 build: bank swap every 4 words, with rd_en bursts of 4 on ram_rd_addr 0..3.
